// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: opcode constants, the NOP word,
// the F/D latch payload type and a predecode helper.
package fetch_stage_pkg;

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  // add r0,r0,r0
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Contents of the F/D pipeline latch.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_updated;
    logic        valid;
    logic        predicted;
  } fd_t;

  // A flushed F/D slot: NOP, no link address, not valid, not predicted.
  localparam fd_t FD_BUBBLE = '{instr: NOP, pc_updated: 32'd0, valid: 1'b0, predicted: 1'b0};

  // True for the unconditional direct jumps whose target sits in the word itself.
  function automatic logic is_direct_jump(input logic [31:0] word);
    return (word[31:27] == OP_J) || (word[31:27] == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// F/D pipeline latch: holds when disabled, loads a bubble when flushed.
module fd_latch
  import fetch_stage_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic flush,
  input  fd_t  d,
  output fd_t  q
);

  // Latch register: async clear, enable-gated load of either the fetched word or a bubble.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= FD_BUBBLE;
    end else if (en) begin
      q <= flush ? FD_BUBBLE : d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection, imem addressing, F/D latch and
// a saturating count of redirect bubbles.
// Optional feature macro: FETCH_PREDECODE_JUMP_EN (redirect j/jal in fetch).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          IMEM_AW  = 12,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  output logic [IMEM_AW-1:0] address_imem,
  input  logic [31:0]        q_imem,
  input  logic               stall,
  input  logic               dx_redirect,
  input  logic [31:0]        dx_target,
  input  logic               ex_redirect,
  input  logic [31:0]        ex_target,
  output logic [31:0]        Instruction,
  output logic [31:0]        PC_updated,
  output logic               fd_valid,
  output logic               fd_predicted,
  output logic [CNT_W-1:0]   flush_count
);

  logic [31:0]    pc;
  logic [31:0]    pc_plus1;
  logic [31:0]    pc_next;
  logic [31:0]    jump_target;
  logic           predict;
  logic [1:0]     flush_inc;
  logic [CNT_W:0] cnt_sum;
  logic           fd_en;
  logic           fd_flush;
  fd_t            fd_d;
  fd_t            fd_q;

  assign address_imem = pc[IMEM_AW-1:0];
  assign pc_plus1     = pc + 32'd1;
  assign jump_target  = {5'b00000, q_imem[26:0]};

`ifdef FETCH_PREDECODE_JUMP_EN
  assign predict = is_direct_jump(q_imem);
`else
  assign predict = 1'b0;
`endif

  // Next-PC priority: execute redirect, then stall, then decode redirect, then sequential/predecoded.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_next   = pc;
    flush_inc = 2'd0;
    if (ex_redirect) begin
      pc_next   = ex_target;
      flush_inc = 2'd2;
    end else if (stall) begin
      pc_next   = pc;
    end else if (dx_redirect) begin
      pc_next   = dx_target;
      flush_inc = 2'd1;
    end else begin
      pc_next   = predict ? jump_target : pc_plus1;
    end
  end

  // PC register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Bubble counter: add with a carry bit and clamp at all-ones on overflow.
  assign cnt_sum = {1'b0, flush_count} + {{(CNT_W-1){1'b0}}, flush_inc};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_count <= '0;
    end else if (cnt_sum[CNT_W]) begin
      flush_count <= '1;
    end else begin
      flush_count <= cnt_sum[CNT_W-1:0];
    end
  end

  // A late redirect beats a stall; a decode redirect under stall is dropped because the latch holds.
  assign fd_en    = ~stall | ex_redirect;
  assign fd_flush = ex_redirect | dx_redirect;
  assign fd_d     = '{instr: q_imem, pc_updated: pc_plus1, valid: 1'b1, predicted: predict};

  fd_latch u_fd_latch (
    .clock (clock),
    .reset (reset),
    .en    (fd_en),
    .flush (fd_flush),
    .d     (fd_d),
    .q     (fd_q)
  );

  assign Instruction  = fd_q.instr;
  assign PC_updated   = fd_q.pc_updated;
  assign fd_valid     = fd_q.valid;
  assign fd_predicted = fd_q.predicted;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the 5-stage pipeline. Drives the word-addressed instruction memory from a 32-bit PC and registers the fetched word plus PC+1 into the F/D latch.
- The decode stage consumes `Instruction` and `PC_updated` from this block. In return, decode sends its fast-branch redirect (`branch_taken`, `PC_branch`) and its stall back here.
- Also accepts the late blt redirect from execute.
- Owns flushing of wrong-path instructions into NOPs (32'h0, i.e. `add r0,r0,r0`).

Parameters:
IMEM_AW, 12, instruction-memory address width; `address_imem = PC[IMEM_AW-1:0]`
RESET_PC, 32'd0, PC value loaded on reset
CNT_W, 16, width of flush-bubble counter

Ports:
clock  in  1  single pipeline clock, rising edge
reset  in  1  asynchronous, active-high
address_imem  out  IMEM_AW  imem word address, combinational from PC
q_imem  in  32  imem read data for address_imem, valid same cycle
stall  in  1  hold PC and F/D latch (hazard / multdiv busy)
dx_redirect  in  1  decode fast-branch taken (j, bne, jal, jr, bex)
dx_target  in  32  decode branch target
ex_redirect  in  1  execute blt taken
ex_target  in  32  execute branch target
Instruction  out  32  F/D latched instruction
PC_updated  out  32  F/D latched PC+1 of that instruction
fd_valid  out  1  F/D holds a real (non-flushed) instruction
fd_predicted  out  1  F/D instruction was already redirected by fetch (optional feature; 0 otherwise)
flush_count  out  CNT_W  number of bubbles inserted by redirects, saturating

Behaviour:
- Reset (async, immediate on assertion):
  - PC = RESET_PC
  - Instruction = 0, PC_updated = 0
  - fd_valid = 0, fd_predicted = 0, flush_count = 0
- First rising edge after reset deasserts latches `imem[RESET_PC]` into F/D.
- Arithmetic:
  - `pc_plus1 = PC + 1`, 32-bit, wraps 0xFFFFFFFF -> 0.
  - Targets are loaded as full 32 bits; only the low IMEM_AW bits address imem.
- Per rising edge, the first matching case wins:
  1. ex_redirect=1 (overrides stall):
     - PC <= ex_target
     - F/D <= NOP, PC_updated <= 0, fd_valid <= 0
     - flush_count += 2 (F/D wrong path plus the word fetched this cycle)
  2. stall=1:
     - PC, F/D and flush_count hold.
     - dx_redirect is ignored; decode re-asserts it once the stall drops.
  3. dx_redirect=1:
     - PC <= dx_target
     - F/D <= NOP, fd_valid <= 0
     - flush_count += 1
  4. Otherwise:
     - F/D <= {q_imem, pc_plus1}, fd_valid <= 1
     - PC <= pc_plus1, or the predecoded target (see Optional Feature)
- Latency: one cycle from PC to F/D. A redirect is visible on address_imem in the cycle after the redirect edge.
- flush_count saturates at all-ones and never wraps.
- Back-to-back redirects on consecutive cycles are each applied, with no lost target.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values asynchronously.

Optional Feature:
- Macro: `FETCH_PREDECODE_JUMP_EN`.
- Enabled, case 4 only:
  - If `q_imem[31:27]` is 5'b00001 (j) or 5'b00011 (jal), then PC <= {5'b0, q_imem[26:0]} and fd_predicted <= 1.
  - F/D still latches the instruction with PC_updated = pc_plus1, so jal links correctly.
  - Decode must suppress dx_redirect when fd_predicted=1.
  - Result: j/jal cost zero bubbles.
- Disabled: fd_predicted is tied to 0; j/jal redirect from decode with a 1-bubble cost.

Decomposition:
- Shared package/header holds:
  - opcode constants: J=5'b00001, BNE=5'b00010, JAL=5'b00011, JR=5'b00100, BLT=5'b00110, BEX=5'b10110
  - NOP = 32'h0
- One natural sub-module, `fd_latch`: a 32+32+2-bit register with async reset, enable (~stall or ex_redirect) and flush (load NOP).
- PC register, next-PC mux and counter stay in fetch_stage.

Test Plan:
- Reset release, imem[0]=32'hAAAA0001, imem[1]=32'hBBBB0002: after edge 1, Instruction=32'hAAAA0001, PC_updated=1, fd_valid=1; after edge 2, PC_updated=2.
- stall=1 for 3 cycles at PC=5: address_imem stays 5 and F/D is unchanged. Then dx_redirect=1 with target 40 while stalled is ignored; after the stall drops, the dx_redirect to 40 yields a NOP in F/D and address_imem=40 next cycle.
- ex_redirect=1 (target 100) with stall=1 and dx_redirect=1 (target 60) in the same cycle: PC=100, F/D=NOP, flush_count+=2.
- PC=32'hFFFFFFFF sequential fetch: PC_updated=0 and PC wraps to 0.
- Force flush_count to all-ones−1, then issue ex_redirect: count saturates at 16'hFFFF.
- With FETCH_PREDECODE_JUMP_EN, imem[3]=jal 20 (32'h18000014): next address_imem=20, Instruction=32'h18000014, PC_updated=4, fd_predicted=1, flush_count unchanged. Without the macro: address_imem=4 and fd_predicted=0.
